// File: rtl/vip_flow_control_output.sv
`default_nettype none
// ============================================================================
// Module  : vip_flow_control_output
// Brief   : Converts a VIP core's write/stall interface into an Avalon-ST Video
//           source, framing each frame as control packet + video packet.
// Revision: 1.0 - initial release
// ============================================================================
module vip_flow_control_output #(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0]  data_out,
    input  logic                                         write,
    input  logic                                         end_of_video_out,
    input  logic [15:0]                                  width_out,
    input  logic [15:0]                                  height_out,
    input  logic [3:0]                                   interlaced_out,
    input  logic                                         vip_ctrl_send,
    output logic                                         stall_out,
    input  logic                                         dout_ready,
    output logic                                         dout_valid,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0]  dout_data,
    output logic                                         dout_startofpacket,
    output logic                                         dout_endofpacket
);

    localparam int c_DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
    localparam int c_EW = c_DW + 2;
    localparam int c_NB = (9 + SYMBOLS_PER_BEAT - 1) / SYMBOLS_PER_BEAT;
    localparam int c_BW = (c_NB > 1) ? $clog2(c_NB) : 1;

    localparam logic [c_DW-1:0] c_CTRL_ID  = c_DW'(4'hF);
    localparam logic [c_DW-1:0] c_VIDEO_ID = '0;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CTRL_HDR  = 3'd1,
        S_CTRL_DATA = 3'd2,
        S_VID_HDR   = 3'd3,
        S_VIDEO     = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_BW-1:0]   r_beat;
    logic [c_BW-1:0]   w_beat_nxt;
    logic [15:0]       r_width;
    logic [15:0]       r_height;
    logic [3:0]        r_interlaced;

    // FIFO entries are {sop, eop, data}; r_head is always the oldest entry
    logic [1:0]        r_count;
    logic [c_EW-1:0]   r_head;
    logic [c_EW-1:0]   r_tail;

    logic              w_can_push;
    logic              w_push;
    logic              w_pop;
    logic [c_EW-1:0]   w_push_ent;
    logic [35:0]       w_nibs;
    logic [c_DW-1:0]   w_ctrl_beat;
    logic              w_last_ctrl;

    assign w_can_push = (r_count != 2'd2);
    assign w_pop      = (r_count != 2'd0) && dout_ready;
    assign w_last_ctrl = (r_beat == c_BW'(c_NB - 1));

    // Nibble i of the control payload sits at w_nibs[4*i +: 4]
    assign w_nibs = {r_interlaced,
                     r_height[3:0], r_height[7:4], r_height[11:8], r_height[15:12],
                     r_width[3:0],  r_width[7:4],  r_width[11:8],  r_width[15:12]};

    always_comb begin
        w_ctrl_beat = '0;
        for (int s = 0; s < SYMBOLS_PER_BEAT; s++) begin
            if (int'(r_beat) * SYMBOLS_PER_BEAT + s < 9) begin
                w_ctrl_beat[s*BITS_PER_SYMBOL +: 4] =
                    w_nibs[(int'(r_beat) * SYMBOLS_PER_BEAT + s) * 4 +: 4];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_push      = 1'b0;
        w_push_ent  = '0;
        stall_out   = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (vip_ctrl_send) begin
                    w_state_nxt = S_CTRL_HDR;
                end
            end
            S_CTRL_HDR: begin
                w_push_ent = {1'b1, 1'b0, c_CTRL_ID};
                if (w_can_push) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_CTRL_DATA;
                end
            end
            S_CTRL_DATA: begin
                w_push_ent = {1'b0, w_last_ctrl, w_ctrl_beat};
                if (w_can_push) begin
                    w_push = 1'b1;
                    if (w_last_ctrl) begin
                        w_beat_nxt  = '0;
                        w_state_nxt = S_VID_HDR;
                    end else begin
                        w_beat_nxt = r_beat + 1'b1;
                    end
                end
            end
            S_VID_HDR: begin
                w_push_ent = {1'b1, 1'b0, c_VIDEO_ID};
                if (w_can_push) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_VIDEO;
                end
            end
            S_VIDEO: begin
                stall_out  = ~w_can_push;
                w_push_ent = {1'b0, end_of_video_out, data_out};
                if (write && w_can_push) begin
                    w_push = 1'b1;
                    if (end_of_video_out) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_beat       <= '0;
            r_width      <= '0;
            r_height     <= '0;
            r_interlaced <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            if (r_state == S_IDLE && vip_ctrl_send) begin
                r_width      <= width_out;
                r_height     <= height_out;
                r_interlaced <= interlaced_out;
            end
        end
    end

    // A simultaneous push and pop can only occur at count 1, so the new beat becomes head
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= w_push_ent;
                    end else begin
                        r_tail <= w_push_ent;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    r_head <= w_push_ent;
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    assign dout_valid         = (r_count != 2'd0);
    assign dout_data          = r_head[c_DW-1:0];
    assign dout_endofpacket   = r_head[c_DW];
    assign dout_startofpacket = r_head[c_DW+1];

endmodule
`default_nettype wire

// File: tb/tb_vip_flow_control_output.sv
`default_nettype none
// ============================================================================
// Module  : tb_vip_flow_control_output
// Brief   : Self-checking bench: vector table, hand sequences, random frames.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vip_flow_control_output;

    localparam int BPS = 8;
    localparam int SPB = 3;
    localparam int DW  = BPS * SPB;
    localparam int NB  = (9 + SPB - 1) / SPB;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] data_out = '0;
    logic          write = 1'b0;
    logic          end_of_video_out = 1'b0;
    logic [15:0]   width_out = '0;
    logic [15:0]   height_out = '0;
    logic [3:0]    interlaced_out = '0;
    logic          vip_ctrl_send = 1'b0;
    logic          stall_out;
    logic          dout_ready = 1'b1;
    logic          dout_valid;
    logic [DW-1:0] dout_data;
    logic          dout_startofpacket;
    logic          dout_endofpacket;

    vip_flow_control_output #(
        .BITS_PER_SYMBOL  (BPS),
        .SYMBOLS_PER_BEAT (SPB)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .data_out           (data_out),
        .write              (write),
        .end_of_video_out   (end_of_video_out),
        .width_out          (width_out),
        .height_out         (height_out),
        .interlaced_out     (interlaced_out),
        .vip_ctrl_send      (vip_ctrl_send),
        .stall_out          (stall_out),
        .dout_ready         (dout_ready),
        .dout_valid         (dout_valid),
        .dout_data          (dout_data),
        .dout_startofpacket (dout_startofpacket),
        .dout_endofpacket   (dout_endofpacket)
    );

    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;
    int          cyc     = 0;
    logic [25:0] exp_q[$];
    int          pop_cyc[$];
    bit          rdy_rand = 1'b0;
    bit          wr_rand  = 1'b0;
    bit          prev_stall = 1'b0;
    logic [25:0] prev_beat = '0;
    logic [25:0] e_beat;

    typedef struct {
        logic [15:0] w;
        logic [15:0] h;
        logic [3:0]  il;
        int          npix;
        logic [23:0] c0;
        logic [23:0] c1;
        logic [23:0] c2;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference control payload built directly from the nibble ordering rule
    function automatic logic [23:0] ctrl_beat(input logic [15:0] w, input logic [15:0] h,
                                              input logic [3:0] il, input int b);
        logic [3:0]  nib [9];
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            nib[i]     = 4'((w >> (12 - 4 * i)) & 16'hF);
            nib[i + 4] = 4'((h >> (12 - 4 * i)) & 16'hF);
        end
        nib[8] = il;
        for (int s = 0; s < SPB; s++)
            if (b * SPB + s < 9) r = r | (24'(nib[b * SPB + s]) << (BPS * s));
        return r;
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rdy_rand) dout_ready = ($urandom_range(0, 1) == 1);
        else          dout_ready = 1'b1;
    end

    // Output monitor: scoreboard compare on every handshake, stability while stalled
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("hold_stable",
                    {5'd0, dout_valid, dout_startofpacket, dout_endofpacket, dout_data},
                    {5'd0, 1'b1, prev_beat});
            if (dout_valid && dout_ready) begin
                pop_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {6'd0, dout_startofpacket, dout_endofpacket, dout_data},
                        32'hFFFF_FFFF);
                end else begin
                    e_beat = exp_q.pop_front();
                    chk("beat", {6'd0, dout_startofpacket, dout_endofpacket, dout_data},
                        {6'd0, e_beat});
                end
            end
            prev_stall = dout_valid && !dout_ready;
            prev_beat  = {dout_startofpacket, dout_endofpacket, dout_data};
        end
    end

    task automatic send_frame(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il,
                              input int npix, input bit model, input bit inject);
        logic [23:0] pix[$];
        int k;
        int guard;
        bit injected;
        injected = 1'b0;
        for (int i = 0; i < npix; i++) pix.push_back(model ? 24'($urandom) : 24'(i + 1));
        if (model) begin
            exp_q.push_back({2'b10, 24'h00000F});
            for (int b = 0; b < NB; b++) exp_q.push_back({1'b0, (b == NB - 1), ctrl_beat(w, h, il, b)});
            exp_q.push_back({2'b10, 24'h000000});
            for (int i = 0; i < npix; i++) exp_q.push_back({1'b0, (i == npix - 1), pix[i]});
        end
        @(posedge clk); #1;
        width_out = w; height_out = h; interlaced_out = il; vip_ctrl_send = 1'b1;
        @(posedge clk); #1;
        vip_ctrl_send = 1'b0;
        @(negedge clk);
        chk("latency_no_beat_yet", {31'd0, dout_valid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("latency_ctrl_hdr", {6'd0, dout_valid, dout_startofpacket, dout_data}, {6'd0, 2'b11, 24'h00000F});
        chk("stall_before_video", {31'd0, stall_out}, 32'd1);
        @(posedge clk); #1;
        k = 0;
        guard = 0;
        while (k < npix && guard < 4000) begin
            vip_ctrl_send = 1'b0;
            if (inject && !injected && k == npix / 2) begin
                vip_ctrl_send = 1'b1;
                width_out     = 16'd9;
                injected      = 1'b1;
            end
            if (!stall_out && (!wr_rand || $urandom_range(0, 9) < 7)) begin
                write = 1'b1; data_out = pix[k]; end_of_video_out = (k == npix - 1); k++;
            end else begin
                write = 1'b0; data_out = 24'($urandom); end_of_video_out = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            guard++;
        end
        write = 1'b0; end_of_video_out = 1'b0; vip_ctrl_send = 1'b0;
        chk("frame_accepted_in_budget", {31'd0, (guard < 4000)}, 32'd1);
    endtask

    task automatic wait_drain(input string name);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk(name, exp_q.size(), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        int k;
        logic [23:0] rpix[3];
        tbl[0] = '{16'd4,    16'd2,    4'h0, 8, 24'h000000, 24'h000004, 24'h000200};
        tbl[1] = '{16'h1234, 16'hABCD, 4'h5, 3, 24'h030201, 24'h0B0A04, 24'h050D0C};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 4'hF, 1, 24'h0F0F0F, 24'h0F0F0F, 24'h0F0F0F};
        tbl[3] = '{16'h0780, 16'h0438, 4'h3, 5, 24'h080700, 24'h040000, 24'h030803};

        // Reset values while reset is held
        #7;
        chk("rst_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_data", {8'd0, dout_data}, 32'd0);
        chk("rst_sop", {31'd0, dout_startofpacket}, 32'd0);
        chk("rst_eop", {31'd0, dout_endofpacket}, 32'd0);
        chk("rst_stall", {31'd0, stall_out}, 32'd1);
        #20 rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("idle_no_beat", {31'd0, dout_valid}, 32'd0);
            chk("idle_stall", {31'd0, stall_out}, 32'd1);
        end

        // Vector table, full-rate sink: exact beat sequence and back-to-back timing
        for (int t = 0; t < 4; t++) begin
            exp_q.push_back({2'b10, 24'h00000F});
            exp_q.push_back({2'b00, tbl[t].c0});
            exp_q.push_back({2'b00, tbl[t].c1});
            exp_q.push_back({2'b01, tbl[t].c2});
            exp_q.push_back({2'b10, 24'h000000});
            for (int i = 1; i <= tbl[t].npix; i++) exp_q.push_back({1'b0, (i == tbl[t].npix), 24'(i)});
            pop_cyc.delete();
            send_frame(tbl[t].w, tbl[t].h, tbl[t].il, tbl[t].npix, 1'b0, 1'b0);
            wait_drain("tbl_drain");
            chk("tbl_beat_count", pop_cyc.size(), 32'(5 + tbl[t].npix));
            chk("tbl_consecutive", 32'(pop_cyc[$] - pop_cyc[0]), 32'(4 + tbl[t].npix));
        end

        // Request pulsed mid-VIDEO must be ignored; next frame uses its own dims
        send_frame(16'd4, 16'd3, 4'h0, 6, 1'b1, 1'b1);
        wait_drain("ignored_req_drain");
        send_frame(16'h0033, 16'h0021, 4'h2, 2, 1'b1, 1'b0);
        wait_drain("after_ignored_drain");

        // Random frames under random backpressure and bursty core writes
        rdy_rand = 1'b1;
        wr_rand  = 1'b1;
        for (int f = 0; f < 12; f++) begin
            send_frame(16'($urandom), 16'($urandom), 4'($urandom), $urandom_range(1, 16), 1'b1, 1'b0);
            wait_drain("rand_drain");
        end
        rdy_rand = 1'b0;
        wr_rand  = 1'b0;
        repeat (2) @(negedge clk);

        // Async reset in the middle of VIDEO
        rpix[0] = 24'h111111; rpix[1] = 24'h222222; rpix[2] = 24'h333333;
        exp_q.push_back({2'b10, 24'h00000F});
        for (int b = 0; b < NB; b++) exp_q.push_back({1'b0, (b == NB - 1), ctrl_beat(16'h0010, 16'h0020, 4'h1, b)});
        exp_q.push_back({2'b10, 24'h000000});
        for (int i = 0; i < 3; i++) exp_q.push_back({2'b00, rpix[i]});
        @(posedge clk); #1;
        width_out = 16'h0010; height_out = 16'h0020; interlaced_out = 4'h1; vip_ctrl_send = 1'b1;
        @(posedge clk); #1;
        vip_ctrl_send = 1'b0;
        k = 0;
        for (int g = 0; g < 50 && k < 3; g++) begin
            if (!stall_out) begin write = 1'b1; data_out = rpix[k]; end_of_video_out = 1'b0; k++; end
            else write = 1'b0;
            @(posedge clk); #1;
        end
        write = 1'b0;
        chk("pre_reset_writes", 32'(k), 32'd3);
        chk("pre_reset_in_video", {31'd0, stall_out}, 32'd0);
        #1 rst = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, dout_valid}, 32'd0);
        chk("midrst_data", {8'd0, dout_data}, 32'd0);
        chk("midrst_sop_eop", {30'd0, dout_startofpacket, dout_endofpacket}, 32'd0);
        chk("midrst_stall", {31'd0, stall_out}, 32'd1);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk); #3 rst = 1'b1;
        // Writes while idle must never reach the output
        write = 1'b1; data_out = 24'hDEAD01; end_of_video_out = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_idle_valid", {31'd0, dout_valid}, 32'd0);
        end
        write = 1'b0; end_of_video_out = 1'b0;
        send_frame(16'h0002, 16'h0001, 4'h0, 1, 1'b1, 1'b0);
        wait_drain("post_rst_frame_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vip_flow_control_output.md
# vip_flow_control_output

Output-side flow-control and packet encoder for VIP algorithm cores. It converts the core's write/stall interface into an Avalon-ST Video source, which is the mirror of the input-side ready/valid to stall/read converter. For each frame it emits a control packet (width, height, interlaced), then a video packet header, then the core's pixels. All beats pass through a 2-entry output FIFO, so `dout_ready` never reaches `stall_out` combinationally.

## Interface
- BITS_PER_SYMBOL, 8, bits per colour symbol; must be ≥4.
- SYMBOLS_PER_BEAT, 3, symbols per beat; legal 1..4.
- clk  in  1  sole clock; all logic rising-edge.
- rst  in  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to clk).
- data_out  in  BPS*SPB  pixel beat from core.
- write  in  1  core presents `data_out`; accepted only when `stall_out`=0.
- end_of_video_out  in  1  qualifies `write`: last pixel of frame.
- width_out  in  16  frame width, sampled on `vip_ctrl_send`.
- height_out  in  16  frame height, sampled on `vip_ctrl_send`.
- interlaced_out  in  4  interlace nibble, sampled on `vip_ctrl_send`.
- vip_ctrl_send  in  1  start-of-frame request.
- stall_out  out  1  1 = core must not write.
- dout_ready  in  1  sink ready.
- dout_valid  out  1  beat valid.
- dout_data  out  BPS*SPB  beat data; symbol 0 in the LSBs.
- dout_startofpacket  out  1  first beat of packet.
- dout_endofpacket  out  1  last beat of packet.

## Operation
- States: IDLE → CTRL_HDR → CTRL_DATA → VID_HDR → VIDEO → IDLE.
- **IDLE:** `stall_out`=1. When `vip_ctrl_send`=1, latch width, height and interlaced, then go to CTRL_HDR. `vip_ctrl_send` is ignored in every other state.
- **Pushing:** the FSM pushes one beat per cycle into the FIFO while count<2. If the FIFO is full, it holds the current beat.
- **CTRL_HDR:** push a beat with symbol0=0xF, other symbols 0, sop=1, eop=0.
- **CTRL_DATA:** push NB=ceil(9/SPB) beats.
  - Nibble sequence i=0..8: width[15:12], [11:8], [7:4], [3:0]; height in the same order; interlaced.
  - Nibble i goes to bits [3:0] of symbol (i mod SPB) of beat floor(i/SPB). Upper symbol bits and unused symbols are 0.
  - sop=0. eop=1 on beat NB-1 only.
  - A beat counter (0..NB-1) wraps to 0 on exit.
- **VID_HDR:** push a beat with symbol0=0x0, other symbols 0, sop=1, eop=0.
- **VIDEO:** `stall_out` = (count==2). Each `write` with `stall_out`=0 pushes {data_out, sop=0, eop=end_of_video_out}. A write with eop=1 returns the FSM to IDLE.
- **Single-pixel frames:** a frame whose first pixel carries `end_of_video_out` is legal and produces a 1-pixel video packet.
- **`write` outside VIDEO:** ignored and never pushed.
- **FIFO:** 2 entries of {data, sop, eop}. The output reflects the head entry. Pop occurs on `dout_valid & dout_ready`. Push and pop in the same cycle keep count unchanged. Push is blocked at count 2 even if a pop occurs that cycle.
- **Avalon-ST rules:** while `dout_valid`=1 and `dout_ready`=0, data/sop/eop are held stable. `dout_valid` never deasserts without a pop.

## Timing
- **Reset values:** `dout_valid`=0, `dout_data`=0, `dout_startofpacket`=0, `dout_endofpacket`=0, `stall_out`=1. State = IDLE, FIFO empty, latched dimensions 0.
- **Reset mid-packet:** the packet is truncated with no eop. The next frame starts cleanly with a control header.
- **Start-up latency:** `vip_ctrl_send` at edge N → CTRL_HDR push at edge N+1 → `dout_valid` with header visible after edge N+1.
- **Pipeline latency:** push to visible output is 1 cycle.
- **Throughput:** with `dout_ready` held 1, one beat per cycle. A full frame occupies 1+NB+1+pixels consecutive cycles, given the core writes whenever `stall_out`=0.
- **Stall timing:** `stall_out` depends only on registered state and count, never combinationally on `dout_ready` or `write`.

## Test plan
- **Reset:** assert `rst`=0 mid-cycle → all outputs take reset values immediately; `stall_out`=1; no beats appear until `vip_ctrl_send`.
- **Basic frame (SPB=3, BPS=8, `dout_ready`=1):** width=4, height=2, interlaced=0, 8 pixels 0x000001..0x000008 → 13 consecutive beats:
  - 0x00000F (sop=1)
  - 0x000000
  - 0x000004
  - 0x000200 (eop=1)
  - 0x000000 (sop=1)
  - pixels 1..8, with eop on 0x000008.
- **Nibble order:** width=0x1234, height=0xABCD, interlaced=0x5 → control beats 0x030201, 0x0B0A04, 0x050D0C.
- **Backpressure:** `dout_ready` pseudo-random at 50% → output sequence identical to the no-backpressure run; data stable while stalled; `stall_out`=1 whenever count=2; no beat lost or duplicated.
- **Ignored request:** `vip_ctrl_send` pulsed mid-VIDEO with width=9 → current frame unaffected; next control packet uses the width latched at the next IDLE request.
- **Reset mid-frame and short frames:**
  - Async reset during VIDEO → `dout_valid`=0 at once; a following frame begins with a 0xF sop beat.
  - 1-pixel frame (eop on the first write) → video packet of header plus 1 beat with eop.
